// File: rtl/axil_crypto_pkg.sv
// Shared definitions for the crypto peripheral AXI4-Lite register bank:
// response codes, write/read FSM encodings and register index decode.
package axil_crypto_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Byte address to register index; byte offset bits are dropped and
    // indices past the bank wrap around.
    function automatic int unsigned reg_index(input logic [31:0] byte_addr,
                                              input int unsigned num_regs);
        return int'((byte_addr >> 2) % num_regs);
    endfunction

    function automatic logic reg_in_range(input logic [31:0] byte_addr,
                                          input int unsigned num_regs);
        return (byte_addr >> 2) < num_regs;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register array for the crypto peripheral: byte-strobed writes,
// one-cycle commit pulses and a combinational read mux.
module axil_reg_bank
    import axil_crypto_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_d;

    always_comb begin
        pulse_d         = '0;
        pulse_d[wr_idx] = wr_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            if (wr_en) begin
                for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                    if (wr_strb[b]) begin
                        regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            wr_pulse <= pulse_d;
        end
    end

    assign rd_data = regs_q[rd_idx];

    always_comb begin
        regs_flat = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_flat[DATA_W*k +: DATA_W] = regs_q[k];
        end
    end

endmodule

// File: rtl/axil_crypto_regs.sv
// AXI4-Lite responder for the crypto peripheral register bank.
// Define AXIL_CRYPTO_REGS_SLVERR_EN to reject out-of-range word indices with SLVERR.
module axil_crypto_regs
    import axil_crypto_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    wr_pulse_o
);

    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    w_state_t          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0]     aw_addr_q, aw_addr_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [DW/8-1:0]   w_strb_q, w_strb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs, b_hs, commit, wr_ok, wr_en;
    logic [IDX_W-1:0]  wr_idx;

    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d, bank_rd;
    logic [1:0]        rresp_q, rresp_d;
    logic              ar_hs, r_hs, rd_ok;
    logic [IDX_W-1:0]  rd_idx;

    logic              unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID  && wready_q;
    assign b_hs  = bvalid_q      && S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID && arready_q;
    assign r_hs  = rvalid_q      && S_AXI_RREADY;

    // ---------------- write channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // The *_d latch values already include a same-cycle handshake, so the
    // commit operands can be taken from them directly.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = S_AXI_WDATA;
                    w_strb_d = S_AXI_WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

`ifdef AXIL_CRYPTO_REGS_SLVERR_EN
    assign wr_ok = reg_in_range(32'(aw_addr_d), NUM_REGS);
    assign rd_ok = reg_in_range(32'(S_AXI_ARADDR), NUM_REGS);
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    assign wr_idx = IDX_W'(reg_index(32'(aw_addr_d), NUM_REGS));
    assign rd_idx = IDX_W'(reg_index(32'(S_AXI_ARADDR), NUM_REGS));

    always_comb begin
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = bresp_q;
        wr_en     = commit && wr_ok;
        if (commit) begin
            bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read mux sees pre-edge register contents, so a read racing a write
    // commit to the same register returns the old value.
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs) begin
            rdata_d = rd_ok ? bank_rd : '0;
            rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axil_reg_bank #(
        .DATA_W   (DW),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (w_data_d),
        .wr_strb   (w_strb_d),
        .rd_idx    (rd_idx),
        .rd_data   (bank_rd),
        .regs_flat (regs_o),
        .wr_pulse  (wr_pulse_o)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule
